// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant in IDLE, one ISSUE cycle with registered operands, then a
// registered result held in RESP until the owning requester takes it.
// Optional grant counters are compiled in when ALU_ARB_STATS_EN is defined.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [OP_W-1:0]   r0_op,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [OP_W-1:0]   r1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]       gnt0_count,
  output logic [15:0]       gnt1_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zero_q, zero_d;
  logic              gnt0, gnt1;

  // Round-robin pick: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    gnt1 = r1_valid & (~r0_valid | ptr_q);
    gnt0 = r0_valid & ~gnt1;
  end

  // Next-state and handshake outputs; inputs are only looked at in IDLE.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    res_d      = res_q;
    zero_d     = zero_q;
    r0_ready   = 1'b0;
    r1_ready   = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        r0_ready = gnt0;
        r1_ready = gnt1;
        if (gnt0) begin
          alu_a_d  = r0_a;
          alu_b_d  = r0_b;
          alu_op_d = r0_op;
          owner_d  = 1'b0;
          state_d  = S_ISSUE;
        end else if (gnt1) begin
          alu_a_d  = r1_a;
          alu_b_d  = r1_b;
          alu_op_d = r1_op;
          owner_d  = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          ptr_d   = ~owner_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, operand and result registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  // Saturating per-requester count of accepted requests.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (r0_valid && r0_ready && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (r1_valid && r1_ready && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign gnt0_count = cnt0_q;
  assign gnt1_count = cnt1_q;
`endif

endmodule
